warp_issue_scheduler: RTL and testbench

- Consumer (reader) side of the instruction-buffer/scoreboard issue interface.
- Each cycle it watches the per-warp ready mask and picks one ready warp round-robin. It then reads that warp's head instruction from the buffer and hands it downstream to operand collection over a valid/ready handshake.
- On downstream acceptance it sends a single commit pulse back to the buffer/scoreboard. The pulse pops the entry and reserves the destination.

---
 rtl/warp_issue_scheduler_pkg.sv | 40 ++++
 rtl/warp_issue_scheduler_rr_arbiter.sv | 33 +++
 rtl/warp_issue_scheduler.sv | 112 +++++++++++
 tb/tb_warp_issue_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/warp_issue_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// sp_pkg: shared sizes, instruction field slices, flag bits, scheduler states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sp_pkg;

  localparam int NUM_WARPS = 32;
  localparam int WID_W     = 5;
  localparam int INST_W    = 63;

  localparam int RD_MSB     = 62;
  localparam int RD_LSB     = 58;
  localparam int RS1_MSB    = 57;
  localparam int RS1_LSB    = 53;
  localparam int RS2_MSB    = 52;
  localparam int RS2_LSB    = 48;
  localparam int OPCODE_MSB = 47;
  localparam int OPCODE_LSB = 40;
  localparam int IMM_MSB    = 39;
  localparam int IMM_LSB    = 8;
  localparam int FLAGS_MSB  = 7;
  localparam int FLAGS_LSB  = 0;

  localparam int FLAG_WR_GPR  = 0;
  localparam int FLAG_WR_UNIR = 1;
  localparam int FLAG_WR_PC   = 2;
  localparam int FLAG_WR_PRED = 3;

  typedef enum logic [1:0] {
    SEL    = 2'd0,
    READ   = 2'd1,
    ISSUE  = 2'd2,
    COMMIT = 2'd3
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/warp_issue_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick, first request at or above ptr
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  always_comb begin
    grant_idx = '0;
    // Descending scans leave the lowest hit; the second pass overrides the
    // wrap-around fallback with the lowest request at or above ptr.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) grant_idx = W'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) grant_idx = W'(i);
    end
    grant = '0;
    if (|req) grant[grant_idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/warp_issue_scheduler.sv
// ---------------------------------------------------------------------------
// warp_issue_scheduler: round-robin warp pick, buffer read, issue handshake
// and single-cycle commit pulse back to the instruction buffer/scoreboard.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module warp_issue_scheduler
  import sp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WARPS-1:0] warp_ready_mask,
  input  logic [INST_W-1:0]    instruction_buffer,
  output logic [WID_W-1:0]     target_warp,
  output logic                 s_tvalid_schedular,
  output logic [4:0]           target_gpr_in,
  output logic [4:0]           target_unir_in,
  output logic                 target_is_pc,
  output logic                 target_is_pred,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [WID_W-1:0]     m_warp_id,
  output logic [INST_W-1:0]    m_inst
);

  sched_state_t state;
  sched_state_t state_nxt;

  logic [WID_W-1:0]     rr_ptr;
  logic [NUM_WARPS-1:0] grant;
  logic [WID_W-1:0]     pick;
  logic                 handshake;
  logic [4:0]           inst_rd;
  logic [7:0]           inst_flags;

  rr_arbiter #(
    .N (NUM_WARPS),
    .W (WID_W)
  ) u_rr_arbiter (
    .req       (warp_ready_mask),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (pick)
  );

  assign handshake  = (state == ISSUE) && m_tready;
  assign inst_rd    = m_inst[RD_MSB:RD_LSB];
  assign inst_flags = m_inst[FLAGS_MSB:FLAGS_LSB];

  always_ff @(posedge clk) begin
    if (rst) state <= SEL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEL:     if (|grant) state_nxt = READ;
      READ:    state_nxt = warp_ready_mask[target_warp] ? ISSUE : SEL;
      ISSUE:   if (m_tready) state_nxt = COMMIT;
      COMMIT:  state_nxt = SEL;
      default: state_nxt = SEL;
    endcase
  end

  always_comb begin
    m_tvalid           = (state == ISSUE);
    s_tvalid_schedular = (state == COMMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_warp <= '0;
      rr_ptr      <= '0;
      m_inst      <= '0;
      m_warp_id   <= '0;
    end else begin
      case (state)
        SEL: if (|grant) target_warp <= pick;
        READ: begin
          // target_warp became the buffer read address one cycle ago, so the
          // head entry is valid on instruction_buffer now.
          if (warp_ready_mask[target_warp]) begin
            m_inst    <= instruction_buffer;
            m_warp_id <= target_warp;
          end
        end
        COMMIT: rr_ptr <= target_warp + 1'b1;
        default: ;
      endcase
    end
  end

  // Reservation fields live only for the commit cycle that follows acceptance.
  always_ff @(posedge clk) begin
    if (rst || !handshake) begin
      target_gpr_in  <= '0;
      target_unir_in <= '0;
      target_is_pc   <= 1'b0;
      target_is_pred <= 1'b0;
    end else begin
      target_gpr_in  <= inst_flags[FLAG_WR_GPR]  ? inst_rd : 5'd0;
      target_unir_in <= inst_flags[FLAG_WR_UNIR] ? inst_rd : 5'd0;
      target_is_pc   <= inst_flags[FLAG_WR_PC];
      target_is_pred <= inst_flags[FLAG_WR_PRED];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_warp_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_warp_issue_scheduler: directed stimulus, per-cycle model comparison
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_warp_issue_scheduler;
  import sp_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_WARPS-1:0] warp_ready_mask;
  logic [INST_W-1:0]    instruction_buffer;
  logic [WID_W-1:0]     target_warp;
  logic                 s_tvalid_schedular;
  logic [4:0]           target_gpr_in;
  logic [4:0]           target_unir_in;
  logic                 target_is_pc;
  logic                 target_is_pred;
  logic                 m_tvalid;
  logic                 m_tready;
  logic [WID_W-1:0]     m_warp_id;
  logic [INST_W-1:0]    m_inst;

  logic [INST_W-1:0] mem [NUM_WARPS];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Buffer head addressed by the registered target_warp.
  assign instruction_buffer = mem[target_warp];

  warp_issue_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .warp_ready_mask    (warp_ready_mask),
    .instruction_buffer (instruction_buffer),
    .target_warp        (target_warp),
    .s_tvalid_schedular (s_tvalid_schedular),
    .target_gpr_in      (target_gpr_in),
    .target_unir_in     (target_unir_in),
    .target_is_pc       (target_is_pc),
    .target_is_pred     (target_is_pred),
    .m_tvalid           (m_tvalid),
    .m_tready           (m_tready),
    .m_warp_id          (m_warp_id),
    .m_inst             (m_inst)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [INST_W-1:0] mk_inst(input logic [4:0] rd, input logic [7:0] flags, input logic [31:0] imm);
    return {rd, 5'd1, 5'd2, 8'h5A, imm, flags};
  endfunction

  // Round robin: scan forward from the pointer modulo the warp count.
  function automatic int rr_pick(input logic [NUM_WARPS-1:0] m, input int p);
    for (int k = 0; k < NUM_WARPS; k++)
      if (m[(p + k) % NUM_WARPS]) return (p + k) % NUM_WARPS;
    return -1;
  endfunction

  // Transaction model: 0 idle, 1 reading head, 2 offering packet, 3 committing.
  int                md_phase = 0;
  int                md_ptr = 0;
  int                md_tw = 0;
  int                md_wid = 0;
  logic [INST_W-1:0] md_inst = '0;

  always @(posedge clk) begin
    if (rst) begin
      md_phase = 0; md_ptr = 0; md_tw = 0; md_wid = 0; md_inst = '0;
    end else begin
      case (md_phase)
        0: if (warp_ready_mask != '0) begin md_tw = rr_pick(warp_ready_mask, md_ptr); md_phase = 1; end
        1: if (warp_ready_mask[md_tw]) begin md_inst = mem[md_tw]; md_wid = md_tw; md_phase = 2; end
           else md_phase = 0;
        2: if (m_tready) md_phase = 3;
        default: begin md_ptr = (md_tw + 1) % NUM_WARPS; md_phase = 0; end
      endcase
    end
    #1;
    chk("model_target_warp", 64'(target_warp), 64'(md_tw));
    chk("model_m_tvalid", 64'(m_tvalid), 64'(md_phase == 2));
    chk("model_pulse", 64'(s_tvalid_schedular), 64'(md_phase == 3));
    if (md_phase == 2) begin
      chk("model_m_inst", 64'(m_inst), 64'(md_inst));
      chk("model_m_warp_id", 64'(m_warp_id), 64'(md_wid));
    end
    chk("model_gpr", 64'(target_gpr_in), (md_phase == 3 && md_inst[0]) ? 64'(md_inst[62:58]) : 64'd0);
    chk("model_unir", 64'(target_unir_in), (md_phase == 3 && md_inst[1]) ? 64'(md_inst[62:58]) : 64'd0);
    chk("model_pc", 64'(target_is_pc), (md_phase == 3) ? 64'(md_inst[2]) : 64'd0);
    chk("model_pred", 64'(target_is_pred), (md_phase == 3) ? 64'(md_inst[3]) : 64'd0);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; warp_ready_mask = '0; m_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pulse(input string nm, input int maxc);
    int n = 0;
    do begin @(negedge clk); n++; end while (!s_tvalid_schedular && n < maxc);
    if (!s_tvalid_schedular) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_valid(input string nm, input int maxc, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!m_tvalid && n < maxc);
    if (!m_tvalid) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int lat;
    int order [4];
    int when [4];
    int np;
    int cyc;

    for (int i = 0; i < NUM_WARPS; i++) mem[i] = mk_inst(5'(i), 8'h01, 32'h1000 + 32'(i));
    rst = 1'b1; warp_ready_mask = '0; m_tready = 1'b0;

    // Reset state
    do_reset();
    chk("reset_target_warp", 64'(target_warp), 64'd0);
    chk("reset_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("reset_m_inst", 64'(m_inst), 64'd0);
    chk("reset_m_warp_id", 64'(m_warp_id), 64'd0);
    chk("reset_pulse", 64'(s_tvalid_schedular), 64'd0);

    // Single warp 3, writes GPR rd=7
    mem[3] = mk_inst(5'd7, 8'h01, 32'hDEADBEEF);
    warp_ready_mask = 32'h1 << 3; m_tready = 1'b1;
    wait_valid("t1_valid", 10, lat);
    chk("t1_latency", 64'(lat), 64'd2);
    chk("t1_warp_id", 64'(m_warp_id), 64'd3);
    wait_pulse("t1_pulse", 10);
    chk("t1_target_warp", 64'(target_warp), 64'd3);
    chk("t1_gpr", 64'(target_gpr_in), 64'd7);
    chk("t1_unir", 64'(target_unir_in), 64'd0);
    warp_ready_mask = '0;
    @(negedge clk);
    chk("t1_gpr_clear", 64'(target_gpr_in), 64'd0);
    // rr_ptr is now 4: warps 2 and 6 ready must pick 6
    warp_ready_mask = (32'h1 << 2) | (32'h1 << 6);
    @(negedge clk);
    chk("t1_ptr_is_4", 64'(target_warp), 64'd6);
    wait_pulse("t1b_pulse", 10);
    warp_ready_mask = '0;

    // Round robin over 1, 5, 30 with wrap
    do_reset();
    warp_ready_mask = (32'h1 << 1) | (32'h1 << 5) | (32'h1 << 30); m_tready = 1'b1;
    np = 0; cyc = 0;
    while (np < 4 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (s_tvalid_schedular) begin order[np] = int'(target_warp); when[np] = cyc; np++; end
    end
    warp_ready_mask = '0;
    chk("t2_pulse_count", 64'(np), 64'd4);
    if (np == 4) begin
      chk("t2_order0", 64'(order[0]), 64'd1);
      chk("t2_order1", 64'(order[1]), 64'd5);
      chk("t2_order2", 64'(order[2]), 64'd30);
      chk("t2_order3_wrap", 64'(order[3]), 64'd1);
      for (int i = 1; i < 4; i++) chk("t2_spacing", 64'(when[i] - when[i-1]), 64'd4);
    end

    // Backpressure on warp 0 for 6 cycles
    do_reset();
    mem[0] = mk_inst(5'd12, 8'h02, 32'hCAFE0000);
    warp_ready_mask = 32'h1; m_tready = 1'b0;
    wait_valid("t3_valid", 10, lat);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3_hold_valid", 64'(m_tvalid), 64'd1);
      chk("t3_hold_inst", 64'(m_inst), 64'(mk_inst(5'd12, 8'h02, 32'hCAFE0000)));
      chk("t3_no_pulse", 64'(s_tvalid_schedular), 64'd0);
    end
    m_tready = 1'b1;
    @(negedge clk);
    chk("t3_pulse_after_accept", 64'(s_tvalid_schedular), 64'd1);
    chk("t3_unir", 64'(target_unir_in), 64'd12);
    chk("t3_valid_cleared", 64'(m_tvalid), 64'd0);
    warp_ready_mask = '0; m_tready = 1'b0;
    @(negedge clk);

    // Abort: warp 2 drops during READ
    do_reset();
    warp_ready_mask = 32'h1 << 2; m_tready = 1'b1;
    @(negedge clk);
    chk("t4_selected", 64'(target_warp), 64'd2);
    warp_ready_mask = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_no_valid", 64'(m_tvalid), 64'd0);
      chk("t4_no_pulse", 64'(s_tvalid_schedular), 64'd0);
      chk("t4_target_hold", 64'(target_warp), 64'd2);
    end
    warp_ready_mask = (32'h1 << 1) | (32'h1 << 3);
    @(negedge clk);
    chk("t4_ptr_unchanged", 64'(target_warp), 64'd1);
    wait_pulse("t4_pulse", 10);
    warp_ready_mask = '0;

    // PC + predicate flags
    do_reset();
    mem[9] = mk_inst(5'd19, 8'h0C, 32'h0);
    warp_ready_mask = 32'h1 << 9; m_tready = 1'b1;
    wait_pulse("t5_pulse", 10);
    chk("t5_pc", 64'(target_is_pc), 64'd1);
    chk("t5_pred", 64'(target_is_pred), 64'd1);
    chk("t5_gpr", 64'(target_gpr_in), 64'd0);
    chk("t5_unir", 64'(target_unir_in), 64'd0);
    warp_ready_mask = '0;
    @(negedge clk);
    chk("t5_clear", 64'({target_gpr_in, target_unir_in, target_is_pc, target_is_pred}), 64'd0);

    // Reset while offering a packet
    do_reset();
    mem[4] = mk_inst(5'd21, 8'h0F, 32'h44);
    warp_ready_mask = 32'h1 << 4; m_tready = 1'b0;
    wait_valid("t6_valid", 10, lat);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_inst", 64'(m_inst), 64'd0);
    chk("t6_rst_warp", 64'(target_warp), 64'd0);
    chk("t6_rst_wid", 64'(m_warp_id), 64'd0);
    chk("t6_rst_fields", 64'({s_tvalid_schedular, target_gpr_in, target_unir_in, target_is_pc, target_is_pred}), 64'd0);
    rst = 1'b0; warp_ready_mask = '0; m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_no_pulse", 64'(s_tvalid_schedular), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
